// File: rtl/spi_stream_arb.sv
// spi_stream_arb: splits read descriptors from N_REQ requesters into engine bursts of at most MAX_BURST words.
// Latency: eng_start two cycles after a descriptor is accepted while idle; NEXT/IDLE/START gap between bursts.
// Backpressure: in RUN the owner's r_ready drives eng_rready directly; a context refuses new work until done.
// Build option: define SPI_STREAM_ARB_RR_EN for round-robin grant; otherwise lowest busy index wins.
module spi_stream_arb #(
   parameter int N_REQ     = 2,
   parameter int MAX_BURST = 64,
   parameter int W_ADDR    = 22,
   parameter int W_COUNT   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*W_ADDR-1:0]    req_addr,
   input  logic [N_REQ*W_COUNT-1:0]   req_count,
   output logic [31:0]                r_data,
   output logic [N_REQ-1:0]           r_valid,
   input  logic [N_REQ-1:0]           r_ready,
   output logic [N_REQ-1:0]           done,
   output logic                       eng_start,
   output logic [W_ADDR-1:0]          eng_addr,
   output logic [W_COUNT-1:0]         eng_count,
   input  logic                       eng_finished,
   input  logic [31:0]                eng_rdata,
   input  logic                       eng_rvalid,
   output logic                       eng_rready
);
   localparam int OW = $clog2(N_REQ);
   localparam int LW = W_COUNT + 1;
   localparam logic [LW-1:0] MAXB = LW'(MAX_BURST);

   typedef enum logic [1:0] {IDLE, START, RUN, NEXT} state_t;

   state_t            state;
   logic [N_REQ-1:0]  busy;
   logic [W_ADDR-1:0] ctx_addr [N_REQ];
   logic [W_COUNT-1:0] ctx_rem [N_REQ];
   logic [OW-1:0]     owner;
   logic [LW-1:0]     blen;
   logic [LW-1:0]     beats;
   logic [LW-1:0]     beats_nxt;
   logic              last;
   logic              fin_seen;
   logic              beat_hs;
   logic              gnt_any;
   logic [OW-1:0]     gnt_idx;
   logic [LW-1:0]     g_rem;
   logic [LW-1:0]     g_len;
   logic              g_last;
`ifdef SPI_STREAM_ARB_RR_EN
   logic [OW-1:0]     rr_ptr;
   logic [OW:0]       rr_sum;
`endif

   assign req_ready = ~busy;

   // Pick the next context to serve; only consumed in IDLE
`ifdef SPI_STREAM_ARB_RR_EN
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      rr_sum  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         rr_sum = {1'b0, rr_ptr} + (OW+1)'(k);
         if (rr_sum >= (OW+1)'(N_REQ))
            rr_sum = rr_sum - (OW+1)'(N_REQ);
         if (!gnt_any && busy[rr_sum[OW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = rr_sum[OW-1:0];
         end
      end
   end
`else
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = N_REQ-1; k >= 0; k--) begin
         if (busy[k]) begin
            gnt_any = 1'b1;
            gnt_idx = OW'(k);
         end
      end
   end
`endif

   // Length of the burst the granted context would issue: min(remaining+1, MAX_BURST)
   always_comb begin
      g_rem  = {1'b0, ctx_rem[gnt_idx]};
      g_last = (g_rem < MAXB);
      g_len  = g_last ? (g_rem + LW'(1)) : MAXB;
   end

   assign beat_hs   = (state == RUN) && eng_rvalid && r_ready[owner];
   assign beats_nxt = (beat_hs && (beats != '0)) ? (beats - LW'(1)) : beats;

   // Data routing: owner sees the engine FIFO in RUN; elsewhere stray words are drained
   always_comb begin
      r_data     = eng_rdata;
      r_valid    = '0;
      eng_rready = 1'b1;
      if (state == RUN) begin
         r_valid[owner] = eng_rvalid;
         eng_rready     = r_ready[owner];
      end
   end

   // Burst scheduler FSM plus per-requester descriptor contexts
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= '0;
         owner     <= '0;
         blen      <= '0;
         beats     <= '0;
         last      <= 1'b0;
         fin_seen  <= 1'b0;
         eng_start <= 1'b0;
         eng_addr  <= '0;
         eng_count <= '0;
         done      <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            ctx_addr[i] <= '0;
            ctx_rem[i]  <= '0;
         end
`ifdef SPI_STREAM_ARB_RR_EN
         rr_ptr    <= OW'(N_REQ-1);
`endif
      end else begin
         eng_start <= 1'b0;
         done      <= '0;
         // idle contexts may load a descriptor in any FSM state
         for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && !busy[i]) begin
               busy[i]     <= 1'b1;
               ctx_addr[i] <= req_addr[i*W_ADDR +: W_ADDR];
               ctx_rem[i]  <= req_count[i*W_COUNT +: W_COUNT];
            end
         end
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  owner     <= gnt_idx;
                  eng_addr  <= ctx_addr[gnt_idx];
                  eng_count <= W_COUNT'(g_len - LW'(1));
                  blen      <= g_len;
                  beats     <= g_len;
                  last      <= g_last;
                  fin_seen  <= 1'b0;
                  eng_start <= 1'b1;
                  state     <= START;
`ifdef SPI_STREAM_ARB_RR_EN
                  rr_ptr    <= gnt_idx;
`endif
               end
            end
            START: state <= RUN;
            RUN: begin
               beats <= beats_nxt;
               if (eng_finished)
                  fin_seen <= 1'b1;
               // leave only when every beat is delivered and the engine has finished
               if ((beats_nxt == '0) && (fin_seen || eng_finished)) begin
                  state        <= NEXT;
                  done[owner]  <= last;
               end
            end
            NEXT: begin
               ctx_addr[owner] <= ctx_addr[owner] + W_ADDR'(blen);
               if (last)
                  busy[owner] <= 1'b0;
               else
                  ctx_rem[owner] <= ctx_rem[owner] - W_COUNT'(blen);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_stream_arb.sv
`timescale 1ns/1ps
module tb_spi_stream_arb;
   localparam int N_REQ = 2, MAX_BURST = 64, W_ADDR = 22, W_COUNT = 16;

   logic clk = 1'b0;
   logic rst;
   logic [N_REQ-1:0]         req_valid, req_ready, r_valid, r_ready, done;
   logic [N_REQ*W_ADDR-1:0]  req_addr;
   logic [N_REQ*W_COUNT-1:0] req_count;
   logic [31:0]              r_data, eng_rdata;
   logic                     eng_start, eng_finished, eng_rvalid, eng_rready;
   logic [W_ADDR-1:0]        eng_addr;
   logic [W_COUNT-1:0]       eng_count;

   always #5 clk = ~clk;

   spi_stream_arb #(.N_REQ(N_REQ), .MAX_BURST(MAX_BURST), .W_ADDR(W_ADDR), .W_COUNT(W_COUNT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_count(req_count),
      .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready), .done(done),
      .eng_start(eng_start), .eng_addr(eng_addr), .eng_count(eng_count),
      .eng_finished(eng_finished), .eng_rdata(eng_rdata), .eng_rvalid(eng_rvalid), .eng_rready(eng_rready)
   );

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // engine model and observation state
   logic [31:0]        eq[$];
   logic [31:0]        popped;
   int                 push_left = 0, fin_cnt = 0, fin_delay = 0;
   logic [W_ADDR-1:0]  push_addr = '0;
   int                 cyc = 0;
   int                 rx_cnt [N_REQ];
   logic [W_ADDR-1:0]  exp_addr [N_REQ];
   int                 done_cnt [N_REQ];
   int                 done_cyc [N_REQ];
   logic               rdy_at_done [N_REQ];
   logic               rdy_after_done [N_REQ];
   logic [N_REQ-1:0]   done_prev = '0;
   int                 last_hs_cyc = 0, fin_cyc = 0;
   logic [W_ADDR-1:0]  st_addr[$];
   logic [W_COUNT-1:0] st_cnt[$];
   int                 st_cyc[$];

   function automatic logic [31:0] wdat(input logic [W_ADDR-1:0] a);
      return {10'h2B3, a};
   endfunction

   function automatic logic [63:0] qa(input int k);
      return (k < st_addr.size()) ? 64'(st_addr[k]) : 64'hFFFF_FFFF;
   endfunction
   function automatic logic [63:0] qc(input int k);
      return (k < st_cnt.size()) ? 64'(st_cnt[k]) : 64'hFFFF_FFFF;
   endfunction
   function automatic int qy(input int k);
      return (k < st_cyc.size()) ? st_cyc[k] : -1000;
   endfunction

   // drive the engine on the falling edge, then observe what the next rising edge will take
   always @(negedge clk) begin
      cyc++;
      eng_finished = 1'b0;
      if (rst) begin
         eq.delete();
         push_left = 0;
         fin_cnt = 0;
      end else begin
         if (push_left > 0) begin
            eq.push_back(wdat(push_addr));
            push_addr++;
            push_left--;
            if (push_left == 0) fin_cnt = fin_delay + 1;
         end
         if (fin_cnt > 0) begin
            fin_cnt--;
            if (fin_cnt == 0) eng_finished = 1'b1;
         end
      end
      eng_rvalid = (eq.size() > 0);
      eng_rdata  = (eq.size() > 0) ? eq[0] : 32'h0;
      #1;
      if (!rst) begin
         if (eng_finished) fin_cyc = cyc;
         if (eng_start) begin
            st_addr.push_back(eng_addr);
            st_cnt.push_back(eng_count);
            st_cyc.push_back(cyc);
            push_left = int'(eng_count) + 1;
            push_addr = eng_addr;
         end
         for (int i = 0; i < N_REQ; i++) begin
            if (done_prev[i]) rdy_after_done[i] = req_ready[i];
            done_prev[i] = done[i];
            if (done[i]) begin
               done_cnt[i]++;
               done_cyc[i] = cyc;
               rdy_at_done[i] = req_ready[i];
            end
            if (r_valid[i] && r_ready[i]) begin
               chk("rdata", r_data, wdat(exp_addr[i]));
               exp_addr[i]++;
               rx_cnt[i]++;
               last_hs_cyc = cyc;
            end
         end
         if (eng_rvalid && eng_rready) popped = eq.pop_front();
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_logs();
      st_addr.delete();
      st_cnt.delete();
      st_cyc.delete();
   endtask

   task automatic send(input int i, input logic [W_ADDR-1:0] a, input logic [W_COUNT-1:0] c, output int t);
      int k;
      @(negedge clk);
      rx_cnt[i] = 0;
      exp_addr[i] = a;
      req_addr[i*W_ADDR +: W_ADDR] = a;
      req_count[i*W_COUNT +: W_COUNT] = c;
      req_valid[i] = 1'b1;
      #2;
      k = 0;
      while (!req_ready[i] && k < 200) begin
         @(negedge clk); #2; k++;
      end
      chk("accept_ready", req_ready[i], 1);
      t = cyc;
      @(negedge clk);
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int i, input int target, input int budget);
      int k = 0;
      while (done_cnt[i] < target && k < budget) begin
         @(negedge clk); #2; k++;
      end
      chk(tag, done_cnt[i], target);
   endtask

   task automatic wait_start(input int n, input int budget);
      int k = 0;
      while (st_addr.size() < n && k < budget) begin
         @(negedge clk); #2; k++;
      end
      chk("start_seen", st_addr.size(), n);
   endtask

   logic [W_ADDR-1:0] exp_a [4];
   int t, s, d0, d1;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req_valid = '0; req_addr = '0; req_count = '0; r_ready = '1;
      eng_finished = 1'b0; eng_rvalid = 1'b0; eng_rdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rx_cnt[i] = 0; exp_addr[i] = '0; done_cnt[i] = 0; done_cyc[i] = 0;
         rdy_at_done[i] = 1'b0; rdy_after_done[i] = 1'b0;
      end
      tick(3); #2;
      chk("rst_req_ready", req_ready, 2'b11);
      chk("rst_r_valid", r_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_eng_start", eng_start, 0);
      chk("rst_eng_addr", eng_addr, 0);
      chk("rst_eng_count", eng_count, 0);
      chk("rst_eng_rready", eng_rready, 1);
      @(negedge clk); rst = 1'b0;
      tick(2);

      // single word descriptor
      clear_logs();
      d0 = done_cnt[0];
      send(0, 22'h000100, 16'd0, t);
      wait_done("t1_done", 0, d0 + 1, 100);
      tick(2);
      chk("t1_nstart", st_addr.size(), 1);
      chk("t1_addr", qa(0), 64'h100);
      chk("t1_count", qc(0), 0);
      chk("t1_latency", qy(0) - t, 2);
      chk("t1_words", rx_cnt[0], 1);
      chk("t1_done_after_beat", done_cyc[0] - last_hs_cyc, 1);
      chk("t1_rdy_at_done", rdy_at_done[0], 0);
      chk("t1_rdy_after_done", rdy_after_done[0], 1);

      // 150 words split into 64+64+22
      clear_logs();
      d0 = done_cnt[0];
      send(0, 22'h000100, 16'd149, t);
      wait_done("t2_done", 0, d0 + 1, 2000);
      tick(4);
      chk("t2_nstart", st_addr.size(), 3);
      chk("t2_cnt0", qc(0), 63);
      chk("t2_cnt1", qc(1), 63);
      chk("t2_cnt2", qc(2), 21);
      chk("t2_addr0", qa(0), 64'h100);
      chk("t2_addr1", qa(1), 64'h140);
      chk("t2_addr2", qa(2), 64'h180);
      chk("t2_words", rx_cnt[0], 150);
      chk("t2_single_done", done_cnt[0], d0 + 1);
      chk("t2_burst_gap", qy(1) - qy(0), 67);

      // two requesters contending
      clear_logs();
      d0 = done_cnt[0]; d1 = done_cnt[1];
      @(negedge clk);
      rx_cnt[0] = 0; rx_cnt[1] = 0;
      exp_addr[0] = 22'h001000; exp_addr[1] = 22'h002000;
      req_addr = {22'h002000, 22'h001000};
      req_count = {16'd127, 16'd127};
      req_valid = 2'b11;
      @(negedge clk);
      req_valid = 2'b00;
      wait_done("t3_done0", 0, d0 + 1, 3000);
      wait_done("t3_done1", 1, d1 + 1, 3000);
`ifdef SPI_STREAM_ARB_RR_EN
      exp_a[0] = 22'h001000; exp_a[1] = 22'h002000; exp_a[2] = 22'h001040; exp_a[3] = 22'h002040;
`else
      exp_a[0] = 22'h001000; exp_a[1] = 22'h001040; exp_a[2] = 22'h002000; exp_a[3] = 22'h002040;
`endif
      chk("t3_nstart", st_addr.size(), 4);
      for (int k = 0; k < 4; k++) chk("t3_grant_order", qa(k), 64'(exp_a[k]));
      chk("t3_words0", rx_cnt[0], 128);
      chk("t3_words1", rx_cnt[1], 128);

      // address wrap between bursts
      clear_logs();
      d1 = done_cnt[1];
      send(1, 22'h3FFFC0, 16'd127, t);
      wait_done("t4_done", 1, d1 + 1, 2000);
      chk("t4_nstart", st_addr.size(), 2);
      chk("t4_addr0", qa(0), 64'h3FFFC0);
      chk("t4_addr1", qa(1), 64'h000000);
      chk("t4_words", rx_cnt[1], 128);

      // late finish plus a 10 cycle requester stall
      clear_logs();
      fin_delay = 5;
      d0 = done_cnt[0];
      send(0, 22'h000200, 16'd31, t);
      wait_start(1, 50);
      s = qy(0);
      tick(5); r_ready[0] = 1'b0;
      tick(10); r_ready[0] = 1'b1;
      wait_done("t5_done", 0, d0 + 1, 300);
      chk("t5_words", rx_cnt[0], 32);
      chk("t5_last_beat", last_hs_cyc - s, 42);
      chk("t5_fin", fin_cyc - s, 37);
      chk("t5_done_cyc", done_cyc[0] - s, 43);

      // late finish, no stall: done waits for the engine
      clear_logs();
      d0 = done_cnt[0];
      send(0, 22'h000240, 16'd31, t);
      wait_done("t5b_done", 0, d0 + 1, 300);
      chk("t5b_words", rx_cnt[0], 32);
      chk("t5b_done_cyc", done_cyc[0] - qy(0), 38);
      fin_delay = 0;

      // reset in the middle of a burst
      clear_logs();
      d0 = done_cnt[0]; d1 = done_cnt[1];
      send(0, 22'h000300, 16'd63, t);
      begin
         int k = 0;
         while (rx_cnt[0] < 44 && k < 300) begin @(negedge clk); #2; k++; end
      end
      chk("t6_beats_before_rst", rx_cnt[0], 44);
      @(negedge clk); rst = 1'b1;
      #2;
      chk("t6_eng_start", eng_start, 0);
      chk("t6_req_ready", req_ready, 2'b11);
      chk("t6_done", done, 0);
      chk("t6_r_valid", r_valid, 0);
      chk("t6_eng_rready", eng_rready, 1);
      tick(3); rst = 1'b0;
      tick(5); #2;
      chk("t6_no_done0", done_cnt[0], d0);
      chk("t6_req_ready_after", req_ready, 2'b11);
      clear_logs();
      send(1, 22'h000400, 16'd9, t);
      wait_done("t6_new_done", 1, d1 + 1, 200);
      chk("t6_new_nstart", st_addr.size(), 1);
      chk("t6_new_addr", qa(0), 64'h400);
      chk("t6_new_count", qc(0), 9);
      chk("t6_new_latency", qy(0) - t, 2);
      chk("t6_new_words", rx_cnt[1], 10);

      tick(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
